// File: rtl/sprite_mem_pkg.sv
// Shared types and defaults for the sprite memory arbiter.
package sprite_mem_pkg;

  localparam int unsigned DEFAULT_ADDR_W       = 14;
  localparam int unsigned DEFAULT_DATA_W       = 12;
  localparam int unsigned DEFAULT_RD_LATENCY   = 2;
  localparam int unsigned DEFAULT_STARVE_LIMIT = 64;
  localparam int unsigned STAT_W               = 16;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_PIX    = 2'd1,
    OWN_AUX_RD = 2'd2
  } owner_t;

  // Owner of the slot issued this cycle; aux writes return nothing.
  function automatic owner_t issue_owner(input logic pix_req,
                                         input logic aux_accept,
                                         input logic aux_we);
    if (pix_req) return OWN_PIX;
    if (aux_accept && !aux_we) return OWN_AUX_RD;
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/sprite_mem_arbiter_if.sv
// Pixel, aux and memory-port signals of the sprite memory arbiter.
interface sprite_mem_arbiter_if
  import sprite_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
);

  logic              pix_req_in;
  logic [ADDR_W-1:0] pix_addr_in;
  logic              pix_valid_out;
  logic [DATA_W-1:0] pix_data_out;

  logic              aux_req_valid_in;
  logic              aux_req_ready_out;
  logic              aux_we_in;
  logic [ADDR_W-1:0] aux_addr_in;
  logic [DATA_W-1:0] aux_wdata_in;
  logic              aux_rsp_valid_out;
  logic [DATA_W-1:0] aux_rsp_data_out;

  logic [ADDR_W-1:0] mem_addr_out;
  logic              mem_we_out;
  logic [DATA_W-1:0] mem_din_out;
  logic [DATA_W-1:0] mem_dout_in;

  // Requesters and memory side.
  modport master (
    output pix_req_in, pix_addr_in,
    output aux_req_valid_in, aux_we_in, aux_addr_in, aux_wdata_in,
    output mem_dout_in,
    input  pix_valid_out, pix_data_out,
    input  aux_req_ready_out, aux_rsp_valid_out, aux_rsp_data_out,
    input  mem_addr_out, mem_we_out, mem_din_out
  );

  // Arbiter side.
  modport slave (
    input  pix_req_in, pix_addr_in,
    input  aux_req_valid_in, aux_we_in, aux_addr_in, aux_wdata_in,
    input  mem_dout_in,
    output pix_valid_out, pix_data_out,
    output aux_req_ready_out, aux_rsp_valid_out, aux_rsp_data_out,
    output mem_addr_out, mem_we_out, mem_din_out
  );

endinterface

// File: rtl/sprite_mem_tag_pipe.sv
// Fixed-depth shift register carrying the owner of each memory slot.
module sprite_mem_tag_pipe
  import sprite_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1 + DEFAULT_RD_LATENCY
) (
  input  logic   clk,
  input  logic   rst_n,
  input  owner_t tag_in,
  output owner_t tag_out
);

  owner_t stages [DEPTH];

  // Reset flushes every in-flight tag so no stale response escapes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stages[i] <= OWN_NONE;
    end else begin
      stages[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/sprite_mem_arbiter.sv
// Single-port sprite memory arbiter: pixel path has absolute priority,
// aux requests fill idle slots; tracks aux stall statistics.
module sprite_mem_arbiter
  import sprite_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W       = DEFAULT_DATA_W,
  parameter int unsigned RD_LATENCY   = DEFAULT_RD_LATENCY,
  parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  sprite_mem_arbiter_if.slave bus,
  input  logic              clear_stats_in,
  output logic [STAT_W-1:0] aux_stall_count_out,
  output logic              aux_starved_out
);

  localparam int unsigned PIPE_DEPTH = 1 + RD_LATENCY;
  localparam int unsigned WAIT_W     = $clog2(STARVE_LIMIT + 1);

  logic              aux_accept_c;
  logic              aux_stall_c;
  logic              aux_write_c;
  logic [ADDR_W-1:0] next_addr_c;
  owner_t            tag_issue_c;
  owner_t            tag_out;
  logic [WAIT_W-1:0] wait_count;

  assign aux_accept_c = bus.aux_req_valid_in & ~bus.pix_req_in;
  assign aux_stall_c  = bus.aux_req_valid_in & bus.pix_req_in;
  assign aux_write_c  = aux_accept_c & bus.aux_we_in;

  // Ready is forced low while reset is asserted so nothing is accepted then.
  assign bus.aux_req_ready_out = aux_accept_c & rst_n_in;

  assign next_addr_c = bus.pix_req_in ? bus.pix_addr_in
                     : aux_accept_c   ? bus.aux_addr_in
                     :                  bus.mem_addr_out;

  assign tag_issue_c = issue_owner(bus.pix_req_in, aux_accept_c, bus.aux_we_in);

  // Registered memory port; address holds on idle cycles.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus.mem_addr_out <= '0;
      bus.mem_we_out   <= 1'b0;
      bus.mem_din_out  <= '0;
    end else begin
      bus.mem_addr_out <= next_addr_c;
      bus.mem_we_out   <= aux_write_c;
      if (aux_write_c) bus.mem_din_out <= bus.aux_wdata_in;
    end
  end

  sprite_mem_tag_pipe #(
    .DEPTH (PIPE_DEPTH)
  ) u_tag_pipe (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .tag_in  (tag_issue_c),
    .tag_out (tag_out)
  );

  // Read data is steered by the tag that lines up with the memory output.
  assign bus.pix_valid_out     = (tag_out == OWN_PIX);
  assign bus.pix_data_out      = (tag_out == OWN_PIX) ? bus.mem_dout_in : DATA_W'(0);
  assign bus.aux_rsp_valid_out = (tag_out == OWN_AUX_RD);
  assign bus.aux_rsp_data_out  = (tag_out == OWN_AUX_RD) ? bus.mem_dout_in : DATA_W'(0);

  // Stall statistics; clear overrides any coincident increment.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      aux_stall_count_out <= '0;
      aux_starved_out     <= 1'b0;
      wait_count          <= '0;
    end else begin
      if (aux_stall_c) begin
        if (wait_count != WAIT_W'(STARVE_LIMIT)) wait_count <= wait_count + WAIT_W'(1);
      end else begin
        wait_count <= '0;
      end

      if (clear_stats_in) begin
        aux_stall_count_out <= '0;
      end else if (aux_stall_c && (aux_stall_count_out != {STAT_W{1'b1}})) begin
        aux_stall_count_out <= aux_stall_count_out + STAT_W'(1);
      end

      if (clear_stats_in) begin
        aux_starved_out <= 1'b0;
      end else if (aux_stall_c && (wait_count >= WAIT_W'(STARVE_LIMIT - 1))) begin
        aux_starved_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Directed self-checking bench for sprite_mem_arbiter with a 2-cycle memory model.
module tb_sprite_mem_arbiter;
  import sprite_mem_pkg::*;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_stats;
  logic [15:0] stall_count;
  logic        starved;
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [DATA_W-1:0] mem     [1<<ADDR_W];
  bit                written [1<<ADDR_W];
  logic [DATA_W-1:0] rd1, rd2;

  sprite_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sprite_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(2), .STARVE_LIMIT(64)
  ) dut (
    .clk_in              (clk),
    .rst_n_in            (rst_n),
    .bus                 (bus),
    .clear_stats_in      (clear_stats),
    .aux_stall_count_out (stall_count),
    .aux_starved_out     (starved)
  );

  always #5 clk = ~clk;

  // Power-up image contents of the memory model.
  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
    if (a == 14'h0041) return 12'hABC;
    if (a == 14'h0100) return 12'h3C7;
    if (a >= 14'h0200 && a < 14'h0208) return 12'hA00 + 12'(a - 14'h0200);
    if (a >= 14'h0300 && a < 14'h0308) return 12'h500 + 12'(a - 14'h0300);
    return 12'h000;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_we_out) begin
      mem[bus.mem_addr_out]     <= bus.mem_din_out;
      written[bus.mem_addr_out] <= 1'b1;
    end
    rd1 <= written[bus.mem_addr_out] ? mem[bus.mem_addr_out] : init_word(bus.mem_addr_out);
    rd2 <= rd1;
  end
  assign bus.mem_dout_in = rd2;

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pix_req_in       = 1'b0;
    bus.pix_addr_in      = '0;
    bus.aux_req_valid_in = 1'b0;
    bus.aux_we_in        = 1'b0;
    bus.aux_addr_in      = '0;
    bus.aux_wdata_in     = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear_stats = 1'b0;
    bus.pix_req_in = 1'b1; bus.pix_addr_in = 14'h0041;
    bus.aux_req_valid_in = 1'b1; bus.aux_we_in = 1'b1;
    bus.aux_addr_in = 14'h0010; bus.aux_wdata_in = 12'h123;
    cyc(); cyc();
    n_checks++; if (bus.aux_req_ready_out !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.aux_req_ready_out); end
    n_checks++; if (bus.mem_addr_out !== 14'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr_out); end
    n_checks++; if (bus.mem_we_out !== 1'b0 || bus.mem_din_out !== 12'h0) begin n_fail++; $display("FAIL reset_mem_wr: got we=%b din=%h expected 0/0", bus.mem_we_out, bus.mem_din_out); end
    n_checks++; if (stall_count !== 16'h0 || starved !== 1'b0) begin n_fail++; $display("FAIL reset_stats: got %h/%b expected 0/0", stall_count, starved); end
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++; if (bus.pix_valid_out !== 1'b0 || bus.aux_rsp_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_no_valid[%0d]: got pix=%b aux=%b expected 0/0", i, bus.pix_valid_out, bus.aux_rsp_valid_out); end
    end
  endtask

  task automatic test_pixel_read();
    bus.pix_req_in = 1'b1; bus.pix_addr_in = 14'h0041;
    cyc();
    idle();
    n_checks++; if (bus.mem_addr_out !== 14'h0041 || bus.mem_we_out !== 1'b0) begin n_fail++; $display("FAIL pix_mem_port: got addr=%h we=%b expected 0041/0", bus.mem_addr_out, bus.mem_we_out); end
    cyc();
    n_checks++; if (bus.pix_valid_out !== 1'b0) begin n_fail++; $display("FAIL pix_early: got %b expected 0", bus.pix_valid_out); end
    cyc();
    n_checks++; if (bus.pix_valid_out !== 1'b1 || bus.pix_data_out !== 12'hABC) begin n_fail++; $display("FAIL pix_data: got v=%b d=%h expected 1/abc", bus.pix_valid_out, bus.pix_data_out); end
    n_checks++; if (bus.aux_rsp_valid_out !== 1'b0) begin n_fail++; $display("FAIL pix_aux_quiet: got %b expected 0", bus.aux_rsp_valid_out); end
    cyc();
    n_checks++; if (bus.pix_valid_out !== 1'b0 || bus.pix_data_out !== 12'h0) begin n_fail++; $display("FAIL pix_after: got v=%b d=%h expected 0/000", bus.pix_valid_out, bus.pix_data_out); end
  endtask

  task automatic test_contention();
    clear_stats = 1'b1; cyc(); clear_stats = 1'b0;
    bus.aux_req_valid_in = 1'b1; bus.aux_we_in = 1'b0; bus.aux_addr_in = 14'h0100;
    bus.pix_req_in = 1'b1; bus.pix_addr_in = 14'h0041;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (bus.aux_req_ready_out !== 1'b0) begin n_fail++; $display("FAIL cont_ready_low[%0d]: got %b expected 0", i, bus.aux_req_ready_out); end
      cyc();
    end
    n_checks++; if (stall_count !== 16'd5) begin n_fail++; $display("FAIL cont_stall_count: got %0d expected 5", stall_count); end
    bus.pix_req_in = 1'b0;
    #1;
    n_checks++; if (bus.aux_req_ready_out !== 1'b1) begin n_fail++; $display("FAIL cont_ready_high: got %b expected 1", bus.aux_req_ready_out); end
    cyc();
    idle();
    n_checks++; if (bus.mem_addr_out !== 14'h0100) begin n_fail++; $display("FAIL cont_mem_addr: got %h expected 0100", bus.mem_addr_out); end
    cyc();
    n_checks++; if (bus.aux_rsp_valid_out !== 1'b0) begin n_fail++; $display("FAIL cont_rsp_early: got %b expected 0", bus.aux_rsp_valid_out); end
    cyc();
    n_checks++; if (bus.aux_rsp_valid_out !== 1'b1 || bus.aux_rsp_data_out !== 12'h3C7) begin n_fail++; $display("FAIL cont_rsp: got v=%b d=%h expected 1/3c7", bus.aux_rsp_valid_out, bus.aux_rsp_data_out); end
    cyc();
    n_checks++; if (bus.aux_rsp_valid_out !== 1'b0 || stall_count !== 16'd5) begin n_fail++; $display("FAIL cont_after: got v=%b cnt=%0d expected 0/5", bus.aux_rsp_valid_out, stall_count); end
  endtask

  task automatic test_write_read();
    bus.aux_req_valid_in = 1'b1; bus.aux_we_in = 1'b1;
    bus.aux_addr_in = 14'h0010; bus.aux_wdata_in = 12'h5A5;
    #1;
    n_checks++; if (bus.aux_req_ready_out !== 1'b1) begin n_fail++; $display("FAIL wr_ready: got %b expected 1", bus.aux_req_ready_out); end
    cyc();
    bus.aux_we_in = 1'b0; bus.aux_wdata_in = 12'h000;
    n_checks++; if (bus.mem_we_out !== 1'b1 || bus.mem_din_out !== 12'h5A5 || bus.mem_addr_out !== 14'h0010) begin n_fail++; $display("FAIL wr_port: got we=%b din=%h addr=%h expected 1/5a5/0010", bus.mem_we_out, bus.mem_din_out, bus.mem_addr_out); end
    cyc();
    idle();
    n_checks++; if (bus.mem_we_out !== 1'b0) begin n_fail++; $display("FAIL wr_pulse: got %b expected 0", bus.mem_we_out); end
    cyc();
    n_checks++; if (bus.aux_rsp_valid_out !== 1'b0) begin n_fail++; $display("FAIL wr_no_rsp: got %b expected 0", bus.aux_rsp_valid_out); end
    cyc();
    n_checks++; if (bus.aux_rsp_valid_out !== 1'b1 || bus.aux_rsp_data_out !== 12'h5A5) begin n_fail++; $display("FAIL raw_rsp: got v=%b d=%h expected 1/5a5", bus.aux_rsp_valid_out, bus.aux_rsp_data_out); end
  endtask

  task automatic test_starvation();
    clear_stats = 1'b1; cyc(); clear_stats = 1'b0;
    bus.aux_req_valid_in = 1'b1; bus.aux_addr_in = 14'h0100; bus.pix_req_in = 1'b1;
    repeat (63) cyc();
    n_checks++; if (starved !== 1'b0) begin n_fail++; $display("FAIL starve_early: got %b expected 0", starved); end
    cyc();
    n_checks++; if (starved !== 1'b1 || stall_count !== 16'd64) begin n_fail++; $display("FAIL starve_set: got %b cnt=%0d expected 1/64", starved, stall_count); end
    idle();
    cyc(); cyc();
    n_checks++; if (starved !== 1'b1) begin n_fail++; $display("FAIL starve_sticky: got %b expected 1", starved); end
    bus.aux_req_valid_in = 1'b1; bus.pix_req_in = 1'b1; clear_stats = 1'b1;
    cyc();
    clear_stats = 1'b0; idle();
    n_checks++; if (stall_count !== 16'd0 || starved !== 1'b0) begin n_fail++; $display("FAIL clear_wins: got cnt=%0d starved=%b expected 0/0", stall_count, starved); end
    cyc();
    n_checks++; if (stall_count !== 16'd0 || starved !== 1'b0) begin n_fail++; $display("FAIL clear_hold: got cnt=%0d starved=%b expected 0/0", stall_count, starved); end
  endtask

  task automatic test_interleaved();
    logic             ev_pix [16];
    logic             ev_aux [16];
    logic [DATA_W-1:0] ed    [16];
    for (int i = 0; i < 16; i++) begin ev_pix[i] = 1'b0; ev_aux[i] = 1'b0; ed[i] = '0; end
    idle();
    repeat (3) cyc();
    for (int n = 0; n < 11; n++) begin
      idle();
      if (n < 8) begin
        if (n % 2 == 0) begin
          bus.pix_req_in = 1'b1; bus.pix_addr_in = 14'h0200 + 14'(n / 2);
          ev_pix[n] = 1'b1; ed[n] = 12'hA00 + 12'(n / 2);
        end else begin
          bus.aux_req_valid_in = 1'b1; bus.aux_addr_in = 14'h0300 + 14'(n / 2);
          ev_aux[n] = 1'b1; ed[n] = 12'h500 + 12'(n / 2);
          #1;
          n_checks++; if (bus.aux_req_ready_out !== 1'b1) begin n_fail++; $display("FAIL il_ready[%0d]: got %b expected 1", n, bus.aux_req_ready_out); end
        end
      end
      cyc();
      if (n >= 2) begin
        n_checks++;
        if (bus.pix_valid_out !== ev_pix[n-2] || bus.aux_rsp_valid_out !== ev_aux[n-2] ||
            bus.pix_data_out !== (ev_pix[n-2] ? ed[n-2] : 12'h0) ||
            bus.aux_rsp_data_out !== (ev_aux[n-2] ? ed[n-2] : 12'h0)) begin
          n_fail++;
          $display("FAIL il_rsp[%0d]: got pix=%b/%h aux=%b/%h expected pix=%b aux=%b data=%h",
                   n - 2, bus.pix_valid_out, bus.pix_data_out, bus.aux_rsp_valid_out,
                   bus.aux_rsp_data_out, ev_pix[n-2], ev_aux[n-2], ed[n-2]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    clear_stats = 1'b1; cyc(); clear_stats = 1'b0;
    bus.aux_req_valid_in = 1'b1; bus.pix_req_in = 1'b1;
    repeat (70000) cyc();
    n_checks++; if (stall_count !== 16'hFFFF || starved !== 1'b1) begin n_fail++; $display("FAIL saturate: got cnt=%h starved=%b expected ffff/1", stall_count, starved); end
    idle();
    clear_stats = 1'b1; cyc(); clear_stats = 1'b0;
    n_checks++; if (stall_count !== 16'h0 || starved !== 1'b0) begin n_fail++; $display("FAIL sat_clear: got cnt=%h starved=%b expected 0/0", stall_count, starved); end
  endtask

  task automatic test_reset_inflight();
    idle();
    repeat (3) cyc();
    bus.pix_req_in = 1'b1; bus.pix_addr_in = 14'h0041;
    cyc();
    idle();
    bus.aux_req_valid_in = 1'b1; bus.aux_addr_in = 14'h0100;
    cyc();
    idle();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.pix_valid_out !== 1'b0 || bus.aux_rsp_valid_out !== 1'b0 || bus.mem_addr_out !== 14'h0) begin n_fail++; $display("FAIL rst_async: got pix=%b aux=%b addr=%h expected 0/0/0000", bus.pix_valid_out, bus.aux_rsp_valid_out, bus.mem_addr_out); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (bus.pix_valid_out !== 1'b0 || bus.aux_rsp_valid_out !== 1'b0 || bus.pix_data_out !== 12'h0 || bus.aux_rsp_data_out !== 12'h0) begin n_fail++; $display("FAIL rst_during[%0d]: got pix=%b/%h aux=%b/%h expected all 0", i, bus.pix_valid_out, bus.pix_data_out, bus.aux_rsp_valid_out, bus.aux_rsp_data_out); end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++;
      if (bus.pix_valid_out !== 1'b0 || bus.aux_rsp_valid_out !== 1'b0 || bus.pix_data_out !== 12'h0 ||
          bus.aux_rsp_data_out !== 12'h0 || bus.mem_addr_out !== 14'h0 || bus.mem_we_out !== 1'b0 ||
          bus.mem_din_out !== 12'h0 || stall_count !== 16'h0 || starved !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_after[%0d]: got pix=%b aux=%b addr=%h we=%b din=%h cnt=%h st=%b expected all 0",
                 i, bus.pix_valid_out, bus.aux_rsp_valid_out, bus.mem_addr_out, bus.mem_we_out,
                 bus.mem_din_out, stall_count, starved);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pixel_read();
    test_contention();
    test_write_read();
    test_starvation();
    test_interleaved();
    test_saturation();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
